// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle controller and the memory
// responder. The controller holds MemRead or MemWrite together with Adr and
// WriteData until MemReady is sampled high. The responder raises MemReady for
// exactly one cycle; Err qualifies MemReady when the request was rejected.
// ReadData is registered and holds its value between reads.
interface mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        Err;

  modport master (
    output MemRead, MemWrite, Adr, WriteData,
    input  ReadData, MemReady, Err
  );

  modport slave (
    input  MemRead, MemWrite, Adr, WriteData,
    output ReadData, MemReady, Err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with a fixed, programmable access latency.
// A valid request is captured in IDLE, waits LATENCY edges in WAIT, performs
// the access and pulses MemReady from RESP. A rejected request, such as a
// misaligned or out-of-range address or both request lines high, goes
// straight to RESP with Err set. In that case storage and ReadData are not
// touched.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2    // legal range 1..15
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  mem_bus,
  output logic [1:0]      dbg_state_o
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             is_wr_q;
  logic             err_q;
  logic [31:0]      rdata_q;

  // Storage is intentionally not reset; contents are undefined until written.
  logic [31:0]      mem_q [DEPTH];

  logic             req_any;
  logic             req_one;
  logic             adr_ok;
  logic             mem_we;

  // Request qualification. Only IDLE looks at these signals, so input
  // activity during WAIT/RESP has no effect.
  assign req_any = mem_bus.MemRead | mem_bus.MemWrite;
  assign req_one = mem_bus.MemRead ^ mem_bus.MemWrite;
  assign adr_ok  = (mem_bus.Adr[1:0] == 2'b00) && (mem_bus.Adr[31:2] < DEPTH_W);

  // The write commits on the final WAIT edge, using only the captured index and data.
  assign mem_we  = (state_q == S_WAIT) && (cnt_q == 4'd0) && is_wr_q;

  // Control FSM with capture registers and the registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            if (req_one && adr_ok) begin
              idx_q   <= mem_bus.Adr[IDX_W+1:2];
              wdata_q <= mem_bus.WriteData;
              is_wr_q <= mem_bus.MemWrite;
              cnt_q   <= LAT_M1;
              err_q   <= 1'b0;
              state_q <= S_WAIT;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!is_wr_q) begin
              rdata_q <= mem_q[idx_q];
            end
            err_q   <= 1'b0;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Storage write port. It is gated by the registered state, so a reset
  // during WAIT drops the pending write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // Outputs are decoded from registered state only.
  assign mem_bus.ReadData = rdata_q;
  assign mem_bus.MemReady = (state_q == S_RESP);
  assign mem_bus.Err      = (state_q == S_RESP) && err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Three instances with LATENCY 2, 1 and 15 share the
// clock and reset. A behavioural model (a word array and the last read value
// per instance) predicts ReadData, Err and the exact MemReady cycle for each
// request. Inputs are driven on the falling edge and outputs are sampled on
// the falling edge.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int NDUT  = 3;

  logic clk;
  logic rst;

  logic        mr   [NDUT];
  logic        mw   [NDUT];
  logic [31:0] adr  [NDUT];
  logic [31:0] wd   [NDUT];
  logic [31:0] rd_o [NDUT];
  logic        rdy  [NDUT];
  logic        err  [NDUT];
  logic [1:0]  st   [NDUT];

  // Reference model
  logic [31:0] mm       [NDUT][DEPTH];
  logic [31:0] rd_model [NDUT];

  int n_chk  = 0;
  int n_pass = 0;

  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : g_dut
      mem_responder_if bus ();
      assign bus.MemRead   = mr[g];
      assign bus.MemWrite  = mw[g];
      assign bus.Adr       = adr[g];
      assign bus.WriteData = wd[g];
      assign rd_o[g]       = bus.ReadData;
      assign rdy[g]        = bus.MemReady;
      assign err[g]        = bus.Err;

      mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
      ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_bus     (bus.slave),
        .dbg_state_o (st[g])
      );
    end
  endgenerate

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one request on instance k and check its response. Call on a
  // falling edge. While the request waits, Adr and WriteData are scrambled;
  // the captured values must still be used.
  task automatic do_req(input int k, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    bit valid;
    int exp_lat;
    int n;
    bit seen;
    int idx;
    valid   = (a[1:0] == 2'b00) && ((a >> 2) < DEPTH) && (r ^ w);
    exp_lat = valid ? lat_of(k) + 1 : 1;
    idx     = int'(a >> 2);
    if (valid) begin
      if (w) mm[k][idx] = d;
      else   rd_model[k] = mm[k][idx];
    end
    mr[k] = r; mw[k] = w; adr[k] = a; wd[k] = d;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (rdy[k]) seen = 1;
      else begin
        adr[k] = $urandom;
        wd[k]  = $urandom;
      end
    end
    check($sformatf("ready_seen[%0d]", k), 32'(seen), 32'd1);
    if (seen) begin
      check($sformatf("latency[%0d]", k), 32'(n), 32'(exp_lat));
      check($sformatf("err[%0d]", k), 32'(err[k]), valid ? 32'd0 : 32'd1);
      check($sformatf("rdata[%0d]", k), rd_o[k], rd_model[k]);
    end
    mr[k] = 1'b0; mw[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("ready_pulse[%0d]", k), {31'd0, rdy[k]}, 32'd0);
  endtask

  task automatic rand_req(input int k);
    int sel;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 15)) << 2;
    else                           a = 32'($urandom_range(252, 255)) << 2;
    case (sel)
      0:       do_req(k, 1'b1, 1'b0, a | 32'($urandom_range(1, 3)), $urandom);
      1:       do_req(k, 1'b0, 1'b1, 32'h400 + (32'($urandom_range(0, 4000)) << 2), $urandom);
      2:       do_req(k, 1'b1, 1'b1, a, $urandom);
      3, 4, 5: do_req(k, 1'b0, 1'b1, a, $urandom);
      default: do_req(k, 1'b1, 1'b0, a, $urandom);
    endcase
  endtask

  initial begin
    bit bad_ready;
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      mr[k] = 1'b0; mw[k] = 1'b0; adr[k] = 32'd0; wd[k] = 32'd0;
      rd_model[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_ready[%0d]", k), {31'd0, rdy[k]}, 32'd0);
      check($sformatf("rst_err[%0d]", k), {31'd0, err[k]}, 32'd0);
      check($sformatf("rst_rdata[%0d]", k), rd_o[k], 32'd0);
    end
    rst = 1'b1;

    // Give every word the bench will read a known value.
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 16; i++) do_req(k, 1'b0, 1'b1, 32'(i) << 2, $urandom);
      for (int i = 252; i < 256; i++) do_req(k, 1'b0, 1'b1, 32'(i) << 2, $urandom);
    end

    // Directed cases on the LATENCY=2 instance.
    do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("wr_rd_value", rd_o[0], 32'hDEADBEEF);
    do_req(0, 1'b1, 1'b0, 32'h13, 32'h0);
    do_req(0, 1'b0, 1'b1, 32'h400, 32'h12345678);
    do_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    do_req(0, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    check("both_no_write", rd_o[0], 32'hDEADBEEF);
    do_req(0, 1'b1, 1'b0, 32'h3FC, 32'h0);

    // Reset pulse during WAIT aborts the write and clears the outputs.
    mw[0] = 1'b1; adr[0] = 32'h20; wd[0] = 32'h5;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    mw[0] = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      rd_model[k] = 32'd0;
      check($sformatf("midrst_ready[%0d]", k), {31'd0, rdy[k]}, 32'd0);
      check($sformatf("midrst_err[%0d]", k), {31'd0, err[k]}, 32'd0);
      check($sformatf("midrst_rdata[%0d]", k), rd_o[k], 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bad_ready = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[0]) bad_ready = 1;
    end
    check("midrst_no_ready", 32'(bad_ready), 32'd0);
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0);

    // Randomized traffic on every instance.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NDUT; k++) begin
        if (k == 2 && (i % 4) != 0) continue;
        rand_req(k);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
